bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter placed in front of the SoC peripheral bus, sharing it between the CPU data port (master 0) and a DMA/debug master (master 1). Each master issues single-beat read/write requests with a req/ack handshake. The arbiter grants the bus with round-robin fairness, drives exactly one slave access cycle per transaction, and returns registered read data with a one-cycle ack pulse. An optional lock holds the grant for atomic read-modify-write sequences.

## Interface
- AW, 32, address width
- DW, 32, data width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1  request, held high until ack
- m0_we, m1_we  in  1  1 = write, 0 = read; stable while req high
- m0_addr, m1_addr  in  AW  byte address; stable while req high
- m0_wdata, m1_wdata  in  DW  write data; stable while req high
- m0_lock, m1_lock  in  1  keep grant after this transaction
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  DW  read data, valid when own ack = 1, held until next own ack
- s_addr  out  AW  slave address
- s_wdata  out  DW  slave write data
- s_we  out  1  slave write strobe, one cycle per write
- s_re  out  1  slave read strobe, one cycle per read
- s_rdata  in  DW  slave read data, combinational in the same cycle as s_re
- grant  out  2  one-hot current owner, 00 when idle

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, pick a winner, register grant, and go to ACCESS. Otherwise stay.
- Winner selection: if only one req is high, that master wins. If both are high, the master other than last_owner wins.
- last_owner resets to 1, so master 0 wins the first tie.
- ACCESS (exactly one cycle):
  - s_addr and s_wdata are driven from the granted master.
  - s_we = granted we; s_re = not granted we.
  - On the edge, s_rdata is captured into the granted master's rdata register (reads only; writes leave rdata unchanged).
  - last_owner is updated, and the FSM goes to RESP.
- RESP: the granted master's ack = 1 for this cycle only. Next state:
  - Lock held: if the granted master's lock was high at ACCESS and its req is still high, keep the grant and go to ACCESS. The arbiter treats the current req as a new transaction.
  - Otherwise, with the granted master's req masked: if the other req is high, grant it and go to ACCESS; else clear grant and go to IDLE.
- Master rule: after seeing ack, a master either drops req the following cycle or presents a new transaction (lock case only). Without lock, a re-raised req waits for the IDLE/RESP arbitration.
- Outside ACCESS: s_we = s_re = 0, s_addr = 0, s_wdata = 0.
- The arbiter never presents both s_we and s_re in the same cycle.
- The arbiter does not decode addresses. Downstream decode to memory, GPIO and PWM is unchanged.

## Timing
- Reset (rst = 0, asynchronous): state = IDLE, grant = 00, last_owner = 1, both acks = 0, both rdata = 0, all s_* outputs = 0. Release is synchronous to clk.
- Uncontended latency: req high before edge N → ACCESS in cycle N → ack high in cycle N+1. Two cycles req-to-ack.
- Back-to-back, contended: throughput is one transaction per 2 cycles, and the masters alternate.
- Simultaneous req in IDLE: only one master is granted. The loser's first ACCESS occurs in the cycle after the winner's RESP.
- Req dropped before ack (protocol violation): the granted access still completes and ack still pulses.
- Lock: can starve the other master indefinitely; this is intentional. Lock is ignored unless the locked master's req is high at RESP.
- Reset asserted mid-ACCESS or mid-RESP: outputs clear immediately, the pending ack is lost, and no further slave strobe occurs.

## Test plan
- Reset: hold rst = 0 with both req = 1 → grant = 00, s_we = s_re = 0, acks 0, rdata 0. Release → m0 is granted first (last_owner = 1).
- Single read: m0 reads addr 0x0001_0004 while the slave returns 0xDEAD_BEEF → s_re high for exactly 1 cycle, m0_ack 1 cycle later, m0_rdata = 0xDEAD_BEEF, m1 signals untouched.
- Contention: both masters write continuously (m0 wdata 0x11, m1 wdata 0x22) → s_we strobes alternate m0, m1, m0, …, one per 2 cycles, and no two consecutive strobes come from the same master.
- Lock: m1 issues 3 locked transactions while m0_req is held → three m1 ACCESS cycles back-to-back at a 2-cycle period, then m0 granted in the next ACCESS after m1 drops lock.
- Write/read exclusivity: random req/we traffic for 10k cycles → s_we & s_re never both 1, at most one ack per cycle, every req eventually acked.
- Async reset mid-transaction: assert rst during the ACCESS cycle → s_re drops within the same cycle, no ack follows, and grant = 00 after release until a new req.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral bus: one slave access cycle
// per transaction, registered read data and a one-cycle ack to the owner.
module bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_we,
  output logic          s_re,
  input  logic [DW-1:0] s_rdata,
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_owner_q, last_owner_d;
  logic          lock_q, lock_d;
  logic [1:0]    ack_q, ack_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          s_we_q, s_we_d;
  logic          s_re_q, s_re_d;
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0] s_wdata_q, s_wdata_d;

  logic [1:0] req;
  logic       owner;
  logic       launch;
  logic       launch_sel;

  assign req   = {m1_req, m0_req};
  assign owner = grant_q[1];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    lock_d       = lock_q;
    ack_d        = 2'b00;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    s_we_d       = 1'b0;
    s_re_d       = 1'b0;
    s_addr_d     = '0;
    s_wdata_d    = '0;
    launch       = 1'b0;
    launch_sel   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          launch     = 1'b1;
          launch_sel = (&req) ? ~last_owner_q : m1_req;
        end
      end
      ACCESS: begin
        if (s_re_q) begin
          if (owner) m1_rdata_d = s_rdata;
          else       m0_rdata_d = s_rdata;
        end
        last_owner_d = owner;
        lock_d       = owner ? m1_lock : m0_lock;
        ack_d        = grant_q;
        state_d      = RESP;
      end
      RESP: begin
        // The owner's own req is masked here unless it asked to keep the bus.
        if (lock_q && req[owner]) begin
          launch     = 1'b1;
          launch_sel = owner;
        end else if (req[~owner]) begin
          launch     = 1'b1;
          launch_sel = ~owner;
        end else begin
          grant_d = 2'b00;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase

    // Slave-side outputs are loaded on the launch edge so they are flop-driven in ACCESS.
    if (launch) begin
      state_d   = ACCESS;
      grant_d   = launch_sel ? 2'b10 : 2'b01;
      s_we_d    = launch_sel ? m1_we    : m0_we;
      s_re_d    = ~s_we_d;
      s_addr_d  = launch_sel ? m1_addr  : m0_addr;
      s_wdata_d = launch_sel ? m1_wdata : m0_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_owner_q <= 1'b1;
      lock_q       <= 1'b0;
      ack_q        <= 2'b00;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      s_we_q       <= 1'b0;
      s_re_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      lock_q       <= lock_d;
      ack_q        <= ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      s_we_q       <= s_we_d;
      s_re_q       <= s_re_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
    end
  end

  assign grant    = grant_q;
  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign s_we     = s_we_q;
  assign s_re     = s_re_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then constrained random traffic.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        lock  [2];

  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_we, s_re;
  logic [1:0]  grant;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return a ^ 32'hDEAC_BEEB;
  endfunction

  // Slave: read data is a fixed function of the address, valid while s_re is high.
  assign s_rdata = s_re ? rd_fn(s_addr) : 32'h0;

  bus_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (req[0]),
    .m0_we    (we[0]),
    .m0_addr  (addr[0]),
    .m0_wdata (wdata[0]),
    .m0_lock  (lock[0]),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m1_req   (req[1]),
    .m1_we    (we[1]),
    .m1_addr  (addr[1]),
    .m1_wdata (wdata[1]),
    .m1_lock  (lock[1]),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_we     (s_we),
    .s_re     (s_re),
    .s_rdata  (s_rdata),
    .grant    (grant)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the bus owner and whether it is in its access or response cycle.
  int          mphase;  // 0 = bus free, 1 = access cycle, 2 = response cycle
  int          mcur;
  int          mlast;
  logic        mlock;
  logic [1:0]  e_grant, e_ack;
  logic        e_we, e_re;
  logic [31:0] e_addr, e_wdata;
  logic [31:0] e_rdata [2];

  function automatic int next_owner();
    if (mphase == 0) begin
      if (req[0] && req[1]) return 1 - mlast;
      if (req[1]) return 1;
      if (req[0]) return 0;
      return -1;
    end
    if (mphase == 2) begin
      if (mlock && req[mcur]) return mcur;
      if (req[1 - mcur]) return 1 - mcur;
      return -1;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mphase     <= 0;
      mcur       <= 0;
      mlast      <= 1;
      mlock      <= 1'b0;
      e_grant    <= 2'b00;
      e_ack      <= 2'b00;
      e_we       <= 1'b0;
      e_re       <= 1'b0;
      e_addr     <= 32'h0;
      e_wdata    <= 32'h0;
      e_rdata[0] <= 32'h0;
      e_rdata[1] <= 32'h0;
    end else begin
      e_ack   <= 2'b00;
      e_we    <= 1'b0;
      e_re    <= 1'b0;
      e_addr  <= 32'h0;
      e_wdata <= 32'h0;
      if (mphase == 1) begin
        if (e_re) e_rdata[mcur] <= rd_fn(e_addr);
        mlast        <= mcur;
        mlock        <= lock[mcur];
        e_ack[mcur]  <= 1'b1;
        mphase       <= 2;
      end else if (next_owner() >= 0) begin
        mcur    <= next_owner();
        mphase  <= 1;
        e_grant <= 2'(1 << next_owner());
        e_we    <= we[next_owner()];
        e_re    <= !we[next_owner()];
        e_addr  <= addr[next_owner()];
        e_wdata <= wdata[next_owner()];
      end else begin
        mphase  <= 0;
        e_grant <= 2'b00;
      end
    end
  end

  always @(negedge clk) begin
    check("grant",    32'(grant),    32'(e_grant));
    check("s_we",     32'(s_we),     32'(e_we));
    check("s_re",     32'(s_re),     32'(e_re));
    check("s_addr",   s_addr,        e_addr);
    check("s_wdata",  s_wdata,       e_wdata);
    check("m0_ack",   32'(m0_ack),   32'(e_ack[0]));
    check("m1_ack",   32'(m1_ack),   32'(e_ack[1]));
    check("m0_rdata", m0_rdata,      e_rdata[0]);
    check("m1_rdata", m1_rdata,      e_rdata[1]);
    check("we_re_excl",  32'(s_we & s_re),     32'd0);
    check("ack_excl",    32'(m0_ack & m1_ack), 32'd0);
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_m(input int i, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic l);
    req[i] = r; we[i] = w; addr[i] = a; wdata[i] = d; lock[i] = l;
  endtask

  function automatic logic ack_of(input int i);
    return (i == 0) ? m0_ack : m1_ack;
  endfunction

  logic pend [2];
  logic drop_next [2];
  int   wait_c [2];

  task automatic new_txn(input int i);
    set_m(i, 1'b1, ($urandom_range(0, 1) == 1), $urandom & 32'hFFFF_FFFC, $urandom,
          ($urandom_range(0, 3) == 0));
    pend[i]   = 1'b1;
    wait_c[i] = 0;
  endtask

  // One cycle of a protocol-abiding random master; 'issue' gates new requests.
  task automatic master_step(input int i, input bit issue);
    if (drop_next[i]) begin
      req[i]       = 1'b0;
      drop_next[i] = 1'b0;
    end else if (pend[i] && ack_of(i)) begin
      check("ack_latency", 32'(wait_c[i] < 200), 32'd1);
      if (lock[i]) begin
        if (issue && $urandom_range(0, 1) == 1) new_txn(i);
        else begin
          req[i] = 1'b0; lock[i] = 1'b0; pend[i] = 1'b0;
        end
      end else begin
        drop_next[i] = 1'b1;
        pend[i]      = 1'b0;
      end
    end else if (pend[i]) begin
      wait_c[i]++;
    end else if (issue && !req[i] && $urandom_range(0, 2) == 0) begin
      new_txn(i);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      set_m(i, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      pend[i] = 1'b0; drop_next[i] = 1'b0; wait_c[i] = 0;
    end
    #1 rst = 1'b0;

    // Reset held with both masters requesting reads.
    set_m(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    set_m(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b0);
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_s_re",  32'(s_re | s_we), 32'd0);
    check("rst_acks",  32'({m0_ack, m1_ack}), 32'd0);
    check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    rst = 1'b1;
    tick();
    check("first_grant_m0", 32'(grant), 32'h1);
    check("first_addr", s_addr, 32'h0000_0100);
    tick();
    check("first_ack_m0", 32'(m0_ack), 32'd1);
    check("first_rdata_m0", m0_rdata, 32'hDEAC_BFEB);
    tick();
    check("second_grant_m1", 32'(grant), 32'h2);
    req[0] = 1'b0;
    tick();
    check("second_rdata_m1", m1_rdata, 32'hDEAC_BCEB);
    tick();
    check("idle_after_pair", 32'(grant), 32'd0);
    req[1] = 1'b0;

    // Single read by m0.
    set_m(0, 1'b1, 1'b0, 32'h0001_0004, 32'h0, 1'b0);
    tick();
    check("sr_s_re", 32'(s_re), 32'd1);
    check("sr_m0_ack_early", 32'(m0_ack), 32'd0);
    tick();
    check("sr_s_re_once", 32'(s_re), 32'd0);
    check("sr_m0_ack", 32'(m0_ack), 32'd1);
    check("sr_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("sr_m1_rdata_kept", m1_rdata, 32'hDEAC_BCEB);
    tick();
    req[0] = 1'b0;
    check("sr_idle", 32'(grant), 32'd0);

    // Contention: m0 last owned the bus, so m1 wins the first tie.
    set_m(0, 1'b1, 1'b1, 32'h0000_1000, 32'h11, 1'b0);
    set_m(1, 1'b1, 1'b1, 32'h0000_2000, 32'h22, 1'b0);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("ct_s_we", 32'(s_we), 32'(k % 2 == 0));
      if (k % 2 == 0) check("ct_wdata", s_wdata, (k % 4 == 0) ? 32'h22 : 32'h11);
    end
    req[0] = 1'b0; req[1] = 1'b0;
    tick();
    check("ct_idle", 32'(grant), 32'd0);

    // Lock: m1 holds the bus for three transactions while m0 waits.
    set_m(1, 1'b1, 1'b1, 32'h0000_4000, 32'h1, 1'b1);
    tick();
    check("lk_grant0", 32'(grant), 32'h2);
    set_m(0, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 1'b0);
    for (int k = 1; k < 3; k++) begin
      tick();
      check("lk_ack", 32'(m1_ack), 32'd1);
      set_m(1, 1'b1, 1'b1, 32'h0000_4000 + 32'(4 * k), 32'(k + 1), 1'b1);
      tick();
      check("lk_grant", 32'(grant), 32'h2);
      check("lk_addr", s_addr, 32'h0000_4000 + 32'(4 * k));
    end
    tick();
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check("lk_m0_grant", 32'(grant), 32'h1);
    check("lk_m0_addr", s_addr, 32'h0000_3000);
    tick();
    check("lk_m0_rdata", m0_rdata, 32'hDEAC_8EEB);
    tick();
    req[0] = 1'b0;

    // Asynchronous reset during an ACCESS cycle.
    set_m(0, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 1'b0);
    tick();
    #1;
    check("ar_pre_s_re", 32'(s_re), 32'd1);
    rst = 1'b0;
    #1;
    check("ar_s_re_drop", 32'(s_re), 32'd0);
    check("ar_grant", 32'(grant), 32'd0);
    req[0] = 1'b0;
    tick();
    check("ar_no_ack", 32'(m0_ack), 32'd0);
    rst = 1'b1;
    repeat (2) begin
      tick();
      check("ar_idle", 32'(grant), 32'd0);
    end
    check("ar_rdata_cleared", m0_rdata, 32'h0);

    // Random protocol-abiding traffic, then drain.
    for (int c = 0; c < 10000; c++) begin
      tick();
      master_step(0, 1'b1);
      master_step(1, 1'b1);
    end
    for (int c = 0; c < 400; c++) begin
      tick();
      master_step(0, 1'b0);
      master_step(1, 1'b0);
    end
    check("drain_pending", 32'({pend[0], pend[1], req[0], req[1]}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
